mgenclk: RTL

Multi-channel, parametrised clock-word generator: a bank of phase-accumulator NCOs, each producing a W-bit oversampled clock word per `i_clk` for a downstream serializer (`xgenclk`-style OSERDES output stage). It extends the single fixed 8-bit word source in three ways:

- Runtime-programmable frequency and phase per channel.
- Phase-continuous frequency retune.
- Glitch-free start/stop: a channel never emits a runt high pulse.

---
 rtl/mgenclk_if.sv | 28 ++
 rtl/mgenclk.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mgenclk_if.sv
// Configuration request and clock-word output bundle of the mgenclk NCO bank.
interface mgenclk_if #(
    parameter int unsigned NCH = 2,
    parameter int unsigned W   = 8,
    parameter int unsigned BW  = 32
);
    localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic             i_cfg_valid;
    logic             o_cfg_ready;
    logic [CW-1:0]    i_cfg_chan;
    logic             i_cfg_en;
    logic             i_cfg_load;
    logic [BW-1:0]    i_cfg_step;
    logic [BW-1:0]    i_cfg_phase;
    logic [NCH*W-1:0] o_word;
    logic [NCH-1:0]   o_ce;

    modport slave (
        input  i_cfg_valid, i_cfg_chan, i_cfg_en, i_cfg_load, i_cfg_step, i_cfg_phase,
        output o_cfg_ready, o_word, o_ce
    );

    modport master (
        output i_cfg_valid, i_cfg_chan, i_cfg_en, i_cfg_load, i_cfg_step, i_cfg_phase,
        input  o_cfg_ready, o_word, o_ce
    );
endinterface

// File: rtl/mgenclk.sv
// Bank of phase-accumulator NCOs emitting W-bit oversampled clock words per clock,
// with runtime frequency/phase programming and runt-free stop.
module mgenclk #(
    parameter int unsigned NCH           = 2,
    parameter int unsigned W             = 8,
    parameter int unsigned BW            = 32,
    parameter bit          OPT_MSB_FIRST = 1'b1
) (
    input  logic     i_clk,
    input  logic     i_reset,
    mgenclk_if.slave bus
);
    localparam int unsigned WLOG = $clog2(W);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_e;

    logic             rdy_q;
    logic             ready_c;
    logic             wr_c;
    logic [BW-1:0]    step_wr_c;

    state_e           st_q      [NCH];
    state_e           st_d      [NCH];
    logic [BW-1:0]    step_q    [NCH];
    logic [BW-1:0]    step_d    [NCH];
    logic [BW-1:0]    phase_q   [NCH];
    logic [BW-1:0]    phase_d   [NCH];
    logic [W-1:0]     s1_word_q [NCH];
    logic [W-1:0]     s1_word_d [NCH];
    logic [NCH-1:0]   s1_ce_q;
    logic [NCH-1:0]   s1_ce_d;
    logic [NCH*W-1:0] word_q;
    logic [NCH-1:0]   ce_q;

    // Sub-sample bits in time order (bit 0 earliest); k*step built from shifted steps.
    function automatic logic [W-1:0] sub_bits(input logic [BW-1:0] ph, input logic [BW-1:0] st);
        logic [W-1:0]  b;
        logic [BW-1:0] mult;
        logic [BW-1:0] p;
        b = '0;
        for (int k = 0; k < int'(W); k++) begin
            mult = '0;
            for (int j = 0; j < int'(WLOG); j++) begin
                if (k[j]) mult = mult + (st << j);
            end
            p    = ph + mult;
            b[k] = p[BW-1];
        end
        return b;
    endfunction

    // Zero every sub-sample from the first falling edge onward.
    function automatic logic [W-1:0] truncate(input logic [W-1:0] b);
        logic [W-1:0] t;
        logic         prev;
        logic         cut;
        prev = 1'b0;
        cut  = 1'b0;
        for (int k = 0; k < int'(W); k++) begin
            if (prev && !b[k]) cut = 1'b1;
            t[k] = cut ? 1'b0 : b[k];
            prev = b[k];
        end
        return t;
    endfunction

    function automatic logic [W-1:0] orient(input logic [W-1:0] b);
        logic [W-1:0] o;
        for (int k = 0; k < int'(W); k++) begin
            o[k] = OPT_MSB_FIRST ? b[int'(W) - 1 - k] : b[k];
        end
        return o;
    endfunction

    assign ready_c   = rdy_q && !i_reset;
    assign wr_c      = bus.i_cfg_valid && ready_c;
    assign step_wr_c = bus.i_cfg_step[BW-1] ? {1'b1, {(BW-1){1'b0}}} : bus.i_cfg_step;

    assign bus.o_cfg_ready = ready_c;
    assign bus.o_word      = word_q;
    assign bus.o_ce        = ce_q;

    // Per-channel FSM, accumulator and stage-1 word selection.
    always_comb begin : next_state
        state_e       nxt;
        logic [W-1:0] raw;
        logic [W-1:0] cut;
        logic         stop;
        s1_ce_d = '0;
        for (int c = 0; c < int'(NCH); c++) begin
            st_d[c]      = st_q[c];
            step_d[c]    = step_q[c];
            phase_d[c]   = phase_q[c];
            s1_word_d[c] = '0;

            raw  = sub_bits(phase_q[c], step_q[c]);
            cut  = truncate(raw);
            stop = (cut != raw) || !raw[W-1];
            nxt  = st_q[c];

            if (st_q[c] != ST_IDLE) begin
                phase_d[c]   = phase_q[c] + (step_q[c] << WLOG);
                s1_ce_d[c]   = 1'b1;
                s1_word_d[c] = (st_q[c] == ST_STOP) ? cut : raw;
                if (st_q[c] == ST_STOP && stop) nxt = ST_IDLE;
            end

            if (wr_c && int'(bus.i_cfg_chan) == c) begin
                step_d[c] = step_wr_c;
                if (bus.i_cfg_en) begin
                    if (nxt == ST_IDLE) phase_d[c] = bus.i_cfg_phase;
                    nxt = ST_RUN;
                end else if (nxt == ST_RUN) begin
                    nxt = ST_STOP;
                end
                if (bus.i_cfg_load) phase_d[c] = bus.i_cfg_phase;
            end

            st_d[c] = nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rdy_q   <= 1'b0;
            s1_ce_q <= '0;
            word_q  <= '0;
            ce_q    <= '0;
            for (int c = 0; c < int'(NCH); c++) begin
                st_q[c]      <= ST_IDLE;
                step_q[c]    <= '0;
                phase_q[c]   <= '0;
                s1_word_q[c] <= '0;
            end
        end else begin
            rdy_q   <= 1'b1;
            s1_ce_q <= s1_ce_d;
            ce_q    <= s1_ce_q;
            for (int c = 0; c < int'(NCH); c++) begin
                st_q[c]             <= st_d[c];
                step_q[c]           <= step_d[c];
                phase_q[c]          <= phase_d[c];
                s1_word_q[c]        <= s1_word_d[c];
                word_q[c*W +: W]    <= orient(s1_word_q[c]);
            end
        end
    end
endmodule
